// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register widths, writeback/destination selects,
// memory-access FSM states and the pipeline latch payloads of the MEM/WB end.
package cpu_types_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned JAL_REG = 31;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_LUI  = 2'd2,
    SEL_NPC  = 2'd3
  } regsel_t;

  typedef enum logic [1:0] {
    DST_RT  = 2'd0,
    DST_RD  = 2'd1,
    DST_JAL = 2'd2
  } regdst_t;

  typedef enum logic {
    IDLE = 1'b0,
    DONE = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic     valid;
    word_t    aluout;
    word_t    stdat;
    word_t    lui;
    word_t    npc;
    regbits_t wsel;
    regsel_t  regsel;
    logic     regwr;
    logic     dren;
    logic     dwen;
    logic     halt;
  } exmem_t;

  typedef struct packed {
    logic     valid;
    logic     regwr;
    regbits_t wsel;
    regsel_t  regsel;
    word_t    aluout;
    word_t    lui;
    word_t    npc;
    word_t    load;
  } memwb_t;

  // Destination encoding 3 aliases rt, matching the decoder's unused slot.
  function automatic regbits_t resolve_dst(input logic [1:0] dst,
                                           input regbits_t rt,
                                           input regbits_t rd);
    case (dst)
      2'(DST_RD):  return rd;
      2'(DST_JAL): return REG_W'(JAL_REG);
      default:     return rt;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_if.sv
// Bundle of the hazard-unit and data-cache signals seen by the MEM/WB stage.
interface mem_wb_if;
  import cpu_types_pkg::*;

  logic  mem_en;
  logic  mem_flush;
  logic  mem_stall;
  logic  dhit;
  word_t dmemload;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;

  modport stage  (input  mem_en, mem_flush, dhit, dmemload,
                  output mem_stall, dmemREN, dmemWEN, dmemaddr, dmemstore);
  modport hazard (output mem_en, mem_flush, input mem_stall);
  modport cache  (output dhit, dmemload,
                  input  dmemREN, dmemWEN, dmemaddr, dmemstore);
endinterface

// File: rtl/wb_mux.sv
// Writeback select: picks the result by regSel and suppresses writes to r0.
module wb_mux
  import cpu_types_pkg::*;
(
  input  logic     i_valid,
  input  logic     i_regwr,
  input  regbits_t i_wsel,
  input  regsel_t  i_regsel,
  input  word_t    i_aluout,
  input  word_t    i_load,
  input  word_t    i_lui,
  input  word_t    i_npc,
  output logic     o_wen,
  output regbits_t o_wsel,
  output word_t    o_wdat
);

  always_comb begin
    o_wdat = i_aluout;
    case (i_regsel)
      SEL_LOAD: o_wdat = i_load;
      SEL_LUI:  o_wdat = i_lui;
      SEL_NPC:  o_wdat = i_npc;
      default:  o_wdat = i_aluout;
    endcase
  end

  assign o_wen  = i_valid & i_regwr & (i_wsel != '0);
  assign o_wsel = i_wsel;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB end of the 5-stage pipeline: EX/MEM and MEM/WB latches, data-cache
// handshake and register-file write port. Define MEM_WB_FWD_EN for forwarding outputs.
module mem_wb_stage
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     mem_en,
  input  logic     mem_flush,
  input  logic     ex_valid,
  input  word_t    ex_aluout,
  input  word_t    ex_stdat,
  input  word_t    ex_lui,
  input  word_t    ex_npc,
  input  regbits_t ex_rt,
  input  regbits_t ex_rd,
  input  logic [1:0] ex_regDst,
  input  logic [1:0] ex_regSel,
  input  logic     ex_regWr,
  input  logic     ex_dREN,
  input  logic     ex_dWEN,
  input  logic     ex_halt,
  input  logic     dhit,
  input  word_t    dmemload,
  output logic     dmemREN,
  output logic     dmemWEN,
  output word_t    dmemaddr,
  output word_t    dmemstore,
  output logic     mem_stall,
  output logic     WEN,
  output regbits_t wsel,
  output word_t    wdat,
  output logic     halt
`ifdef MEM_WB_FWD_EN
  ,
  output logic     fwd_mem_valid,
  output regbits_t fwd_mem_sel,
  output word_t    fwd_mem_dat,
  output logic     fwd_wb_valid,
  output regbits_t fwd_wb_sel,
  output word_t    fwd_wb_dat
`endif
);

  mem_wb_if u_bus ();

  exmem_t     r_exmem;
  memwb_t     r_memwb;
  mem_state_t r_state;
  word_t      r_hold;
  logic       r_halt;

  exmem_t     w_exmem_next;
  logic       w_req;
  logic       w_load_en;
  word_t      w_load_data;

  assign u_bus.mem_en    = mem_en;
  assign u_bus.mem_flush = mem_flush;
  assign u_bus.dhit      = dhit;
  assign u_bus.dmemload  = dmemload;

  // Requests drop once the access has completed and the pipeline is still held.
  assign u_bus.dmemWEN   = r_exmem.valid & r_exmem.dwen & (r_state != DONE);
  assign u_bus.dmemREN   = r_exmem.valid & r_exmem.dren & ~r_exmem.dwen & (r_state != DONE);
  assign u_bus.dmemaddr  = r_exmem.aluout;
  assign u_bus.dmemstore = r_exmem.stdat;
  assign w_req           = u_bus.dmemREN | u_bus.dmemWEN;
  assign u_bus.mem_stall = w_req & ~u_bus.dhit;

  // An enable arriving during a stall is ignored so the access always completes.
  assign w_load_en   = u_bus.mem_en & ~u_bus.mem_stall;
  assign w_load_data = (w_req & u_bus.dhit) ? u_bus.dmemload : r_hold;

  assign dmemREN   = u_bus.dmemREN;
  assign dmemWEN   = u_bus.dmemWEN;
  assign dmemaddr  = u_bus.dmemaddr;
  assign dmemstore = u_bus.dmemstore;
  assign mem_stall = u_bus.mem_stall;
  assign halt      = r_halt;

  always_comb begin
    w_exmem_next        = '0;
    w_exmem_next.valid  = ex_valid;
    w_exmem_next.aluout = ex_aluout;
    w_exmem_next.stdat  = ex_stdat;
    w_exmem_next.lui    = ex_lui;
    w_exmem_next.npc    = ex_npc;
    w_exmem_next.wsel   = resolve_dst(ex_regDst, ex_rt, ex_rd);
    w_exmem_next.regsel = regsel_t'(ex_regSel);
    w_exmem_next.regwr  = ex_regWr;
    w_exmem_next.dren   = ex_dREN;
    w_exmem_next.dwen   = ex_dWEN;
    w_exmem_next.halt   = ex_halt;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_exmem <= '0;
    end else if (w_load_en) begin
      if (u_bus.mem_flush) r_exmem <= '0;
      else                 r_exmem <= w_exmem_next;
    end
  end

  // Access FSM: DONE remembers a completed access while the pipeline is held.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req & u_bus.dhit) begin
            r_hold <= u_bus.dmemload;
            if (!u_bus.mem_en) r_state <= DONE;
          end
        end
        DONE: begin
          if (u_bus.mem_en) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_memwb <= '0;
      r_halt  <= 1'b0;
    end else if (w_load_en) begin
      r_memwb.valid  <= r_exmem.valid;
      r_memwb.regwr  <= r_exmem.regwr;
      r_memwb.wsel   <= r_exmem.wsel;
      r_memwb.regsel <= r_exmem.regsel;
      r_memwb.aluout <= r_exmem.aluout;
      r_memwb.lui    <= r_exmem.lui;
      r_memwb.npc    <= r_exmem.npc;
      r_memwb.load   <= w_load_data;
      if (r_exmem.valid & r_exmem.halt) r_halt <= 1'b1;
    end
  end

  wb_mux u_wb (
    .i_valid  (r_memwb.valid),
    .i_regwr  (r_memwb.regwr),
    .i_wsel   (r_memwb.wsel),
    .i_regsel (r_memwb.regsel),
    .i_aluout (r_memwb.aluout),
    .i_load   (r_memwb.load),
    .i_lui    (r_memwb.lui),
    .i_npc    (r_memwb.npc),
    .o_wen    (WEN),
    .o_wsel   (wsel),
    .o_wdat   (wdat)
  );

`ifdef MEM_WB_FWD_EN
  // Loads are not forwardable from EX/MEM; their data is not back yet.
  wb_mux u_fwd (
    .i_valid  (r_exmem.valid & ~r_exmem.dren),
    .i_regwr  (r_exmem.regwr),
    .i_wsel   (r_exmem.wsel),
    .i_regsel (r_exmem.regsel),
    .i_aluout (r_exmem.aluout),
    .i_load   ('0),
    .i_lui    (r_exmem.lui),
    .i_npc    (r_exmem.npc),
    .o_wen    (fwd_mem_valid),
    .o_wsel   (fwd_mem_sel),
    .o_wdat   (fwd_mem_dat)
  );

  assign fwd_wb_valid = WEN;
  assign fwd_wb_sel   = wsel;
  assign fwd_wb_dat   = wdat;
`endif

endmodule
